serial_rx: RTL
==============

SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal values are even and ≥4.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port en  input  1  global enable; when low, FSM, counters and shift register hold their values.
REQ-006 SHALL have port rx  input  1  serial line; idle-high, asynchronous to clk.
REQ-007 SHALL have port data  output  WIDTH  last correctly framed word.
REQ-008 SHALL have port valid  output  1  one-cycle pulse when data is updated.
REQ-009 SHALL have port frame_err  output  1  stop bit of the last frame was sampled low.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL pass rx through a two-flop synchronizer (rx_s) that runs regardless of en; the FSM uses only rx_s.
REQ-012 SHALL use the frame format: start bit 0, then WIDTH data bits LSB first, then one stop bit 1.
REQ-013 SHALL implement states IDLE, START, DATA, STOP and WAIT_IDLE with a bit-period counter cnt and a bit index idx.
REQ-014 IDLE: on an enabled edge with rx_s=0 → START, cnt=0.
REQ-015 START: cnt increments each enabled edge; on the edge with cnt=CLKS_PER_BIT/2-1, if rx_s=0 → DATA with cnt=0 and idx=0; otherwise (glitch) → IDLE with no output change.
REQ-016 DATA: on the edge with cnt=CLKS_PER_BIT-1, the shift register SHALL shift right, inserting rx_s at the MSB (sh={rx_s, sh[WIDTH-1:1]}), then cnt=0 and idx+1; after sample WIDTH-1 → STOP.
REQ-017 STOP: on the edge with cnt=CLKS_PER_BIT-1, if rx_s=1: data=sh, valid=1, frame_err=0, → IDLE.
REQ-018 STOP: on that same edge, if rx_s=0: data unchanged, valid=0, frame_err=1, → WAIT_IDLE.
REQ-019 WAIT_IDLE: remain until rx_s=1, then → IDLE; a line held low (break) SHALL NOT start a new frame.
REQ-020 valid SHALL be high for exactly one clk cycle per good frame and SHALL deassert on the next edge even if en=0.
REQ-021 frame_err SHALL stay high until the next STOP-state sample.
REQ-022 Latency: FSM leaves IDLE on edge E0; the data sample for bit k SHALL be on edge E0+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT; the valid edge SHALL be E0+CLKS_PER_BIT/2+(WIDTH+1)·CLKS_PER_BIT.
REQ-023 en low mid-frame SHALL freeze state, cnt, idx and sh; the frame resumes where it stopped when en returns high.
REQ-024 Back-to-back frames (the next start bit immediately after the stop bit) SHALL be received without loss.

Reset
REQ-025 rst high SHALL immediately force: state=IDLE, cnt=0, idx=0, sh=0, data=0, valid=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-026 rst asserted mid-frame SHALL abandon the frame; no valid pulse; reception restarts at the next falling rx_s after rst is released.

Verification (WIDTH=8, CLKS_PER_BIT=4)
REQ-027 Send frame 0xA5 with a correct stop bit → data=0xA5, valid high for one cycle, frame_err=0, at the REQ-022 edge.
REQ-028 Send 0x3C with stop bit 0, line low for 40 cycles, then high; then send 0x81 → no valid pulse for 0x3C; frame_err=1 and data keeps its previous value; busy stays high until rx returns high; 0x81 is received with frame_err cleared.
REQ-029 Apply a 1-cycle low glitch on idle rx → FSM returns to IDLE from START; no valid pulse; data unchanged.
REQ-030 Send 0x55 then 0xFF back-to-back → two valid pulses exactly 40 cycles apart, data=0x55 then 0xFF.
REQ-031 Drop en for 7 cycles during bit 3 of 0x96 → data=0x96, with valid delayed by exactly 7 cycles.
REQ-032 Assert rst during bit 5 of 0xF0 → all outputs 0 immediately; a subsequent 0x0F is received correctly.

Source files
------------

// File: rtl/serial_rx.sv
// ---------------------------------------------------------------------------
// serial_rx
//
// Receives asynchronous serial frames: one start bit (0), WIDTH data bits
// sent LSB first, then one stop bit (1). The rx line is first brought into
// the clk domain through a two-flop synchronizer. Each bit is then sampled
// at its centre using a bit-period counter.
//
// Parameters
//   WIDTH         data bits per frame (>= 2)
//   CLKS_PER_BIT  clk cycles per serial bit (even, >= 4)
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   en           in   global enable; when low, FSM, counters and shifter hold
//   rx           in   serial line, idle-high, asynchronous to clk
//   data         out  last correctly framed word
//   valid        out  one-cycle pulse when data is updated
//   frame_err    out  stop bit of the last frame was sampled low
//   busy         out  high in every state except IDLE
//   dbg_state_o  out  current FSM state, for observation only
//
// Handshake: valid is a single-cycle strobe with no ready. data is stable
// from the valid cycle until the next good frame, so a consumer may sample
// data on the valid cycle or at any later time.
// ---------------------------------------------------------------------------
module serial_rx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rx,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             frame_err,
    output logic             busy,
    output logic [2:0]       dbg_state_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Synchronizer runs regardless of en. It resets to 1 so that a reset
    // release never looks like a falling edge on the line.
    logic rx_meta_q, rx_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        // valid is a strobe: it drops on the next edge even while en is low.
        valid_d = 1'b0;
        ferr_d  = ferr_q;

        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end

                S_START: begin
                    // Re-check the line half a bit in: a low that has already
                    // gone away was a glitch, not a start bit.
                    if (cnt_q == CNT_HALF) begin
                        cnt_d = '0;
                        if (!rx_s_q) begin
                            state_d = S_DATA;
                            idx_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        // LSB arrives first, so shifting in at the MSB leaves
                        // bit 0 of the word in sh[0] after WIDTH samples.
                        sh_d  = {rx_s_q, sh_q[WIDTH-1:1]};
                        cnt_d = '0;
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (rx_s_q) begin
                            data_d  = sh_q;
                            valid_d = 1'b1;
                            ferr_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            // Low stop bit: the line may be in a break, so
                            // wait for it to go high before hunting again.
                            ferr_d  = 1'b1;
                            state_d = S_WAIT_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_WAIT_IDLE: begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_err   = ferr_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule
